// File: rtl/ysyx_bus_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_bus_pkg
// Shared definitions for the LSU-to-AXI4-Lite bridge:
//   - lsu_state_e : bridge FSM states
//   - RESP_*      : AXI4-Lite response codes
//   - lane_bit_shift / lane_strb : byte-lane alignment helpers for a
//     32-bit (4-lane) data path, keyed on the low two address bits
// ---------------------------------------------------------------------------
package ysyx_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RADDR = 3'd1,
    ST_RDATA = 3'd2,
    ST_WREQ  = 3'd3,
    ST_WRESP = 3'd4,
    ST_HOLD  = 3'd5
  } lsu_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Bit distance between lane 0 and the lane selected by the byte offset.
  function automatic logic [4:0] lane_bit_shift(input logic [1:0] off);
    lane_bit_shift = {off, 3'b000};
  endfunction

  // Move a low-aligned byte strobe up to its lane; bits pushed past lane 3
  // are dropped, which is how misaligned accesses get truncated.
  function automatic logic [3:0] lane_strb(input logic [3:0] strb, input logic [1:0] off);
    lane_strb = strb << off;
  endfunction

endpackage

// File: rtl/ysyx_lsu_axi.sv
// ---------------------------------------------------------------------------
// ysyx_lsu_axi
// Bridge between the LSU's level-held load/store requests and one AXI4-Lite
// master port. Exactly one AXI transaction runs per request, one at a time.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   lsu_araddr/arvalid/rstrb load request (held until lsu_rvalid)
//   lsu_rdata/rvalid         load result, shifted down to bit 0, 1-cycle pulse
//   lsu_awaddr/wdata/wstrb   store request, low-aligned data and size
//   lsu_awvalid/wvalid       store request valids (held until lsu_wready)
//   lsu_wready               1-cycle store-complete pulse
//   lsu_err                  1-cycle pulse with the completion when RESP != OKAY
//   m_ar*/m_r*/m_aw*/m_w*/m_b*  AXI4-Lite master channels
//
// All outputs come straight from registers, so the asynchronous reset clears
// every valid/ready at once and abandons any in-flight AXI transaction.
// The lane alignment logic assumes a 32-bit (4-lane) data path.
// ---------------------------------------------------------------------------
module ysyx_lsu_axi
  import ysyx_bus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // LSU load side
  input  logic [ADDR_W-1:0]     lsu_araddr,
  input  logic                  lsu_arvalid,
  input  logic [7:0]            lsu_rstrb,
  output logic [DATA_W-1:0]     lsu_rdata,
  output logic                  lsu_rvalid,
  // LSU store side
  input  logic [ADDR_W-1:0]     lsu_awaddr,
  input  logic [DATA_W-1:0]     lsu_wdata,
  input  logic [7:0]            lsu_wstrb,
  input  logic                  lsu_awvalid,
  input  logic                  lsu_wvalid,
  output logic                  lsu_wready,
  output logic                  lsu_err,
  // AXI4-Lite read address
  output logic [ADDR_W-1:0]     m_araddr,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  // AXI4-Lite read data
  input  logic [DATA_W-1:0]     m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  // AXI4-Lite write address
  output logic [ADDR_W-1:0]     m_awaddr,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  // AXI4-Lite write data
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_wstrb,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  // AXI4-Lite write response
  input  logic [1:0]            m_bresp,
  input  logic                  m_bvalid,
  output logic                  m_bready
);

  localparam int LANES = DATA_W / 8;

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [LANES-1:0]  wstrb_q, wstrb_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              bready_q, bready_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic              rvalid_q, rvalid_d;
  logic              wready_q, wready_d;
  logic              err_q, err_d;

  logic [3:0]        wstrb_lane_s;
  logic              unused_s;

  assign wstrb_lane_s = lane_strb(lsu_wstrb[3:0], lsu_awaddr[1:0]);

  // Read size only matters to the LSU's own extension logic; upper strobe
  // bits are never set for 32-bit accesses.
  assign unused_s = ^{lsu_rstrb, lsu_wstrb[7:4]};

  // Next-state and next-output logic for the bridge FSM.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rvalid_d  = 1'b0;
    wready_d  = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Loads take priority when both requests are present.
        if (lsu_arvalid) begin
          addr_d    = lsu_araddr;
          arvalid_d = 1'b1;
          state_d   = ST_RADDR;
        end else if (lsu_awvalid && lsu_wvalid) begin
          addr_d    = lsu_awaddr;
          wdata_d   = lsu_wdata << lane_bit_shift(lsu_awaddr[1:0]);
          wstrb_d   = wstrb_lane_s;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = ST_WREQ;
        end else begin
          state_d   = ST_IDLE;
        end
      end

      ST_RADDR: begin
        if (m_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RDATA;
        end else begin
          arvalid_d = 1'b1;
        end
      end

      ST_RDATA: begin
        if (m_rvalid) begin
          rready_d = 1'b0;
          rdata_d  = m_rdata >> lane_bit_shift(addr_q[1:0]);
          rvalid_d = 1'b1;
          err_d    = (m_rresp != RESP_OKAY);
          state_d  = ST_HOLD;
        end else begin
          rready_d = 1'b1;
        end
      end

      ST_WREQ: begin
        // AW and W complete independently; each valid drops after its own
        // handshake and the response phase starts once both are done.
        aw_done_d = aw_done_q | (awvalid_q & m_awready);
        w_done_d  = w_done_q  | (wvalid_q  & m_wready);
        awvalid_d = ~aw_done_d;
        wvalid_d  = ~w_done_d;
        if (aw_done_d && w_done_d) begin
          bready_d = 1'b1;
          state_d  = ST_WRESP;
        end else begin
          state_d  = ST_WREQ;
        end
      end

      ST_WRESP: begin
        if (m_bvalid) begin
          bready_d = 1'b0;
          wready_d = 1'b1;
          err_d    = (m_bresp != RESP_OKAY);
          state_d  = ST_HOLD;
        end else begin
          bready_d = 1'b1;
        end
      end

      // The requester is dropping its request during this cycle, so it
      // must not be sampled again.
      ST_HOLD: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d   = ST_IDLE;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= {ADDR_W{1'b0}};
      wdata_q   <= {DATA_W{1'b0}};
      wstrb_q   <= {LANES{1'b0}};
      rdata_q   <= {DATA_W{1'b0}};
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      wready_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rvalid_q  <= rvalid_d;
      wready_q  <= wready_d;
      err_q     <= err_d;
    end
  end

  assign m_araddr   = addr_q;
  assign m_awaddr   = addr_q;
  assign m_arvalid  = arvalid_q;
  assign m_rready   = rready_q;
  assign m_awvalid  = awvalid_q;
  assign m_wvalid   = wvalid_q;
  assign m_wdata    = wdata_q;
  assign m_wstrb    = wstrb_q;
  assign m_bready   = bready_q;
  assign lsu_rdata  = rdata_q;
  assign lsu_rvalid = rvalid_q;
  assign lsu_wready = wready_q;
  assign lsu_err    = err_q;

endmodule

// File: tb/tb_ysyx_lsu_axi.sv
// ---------------------------------------------------------------------------
// tb_ysyx_lsu_axi
// Directed bench for ysyx_lsu_axi. The bench plays both the LSU and the AXI
// slave. Expected completions are queued when a request is issued and are
// popped whenever the DUT produces lsu_rvalid / lsu_wready.
// ---------------------------------------------------------------------------
module tb_ysyx_lsu_axi;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] lsu_araddr;
  logic        lsu_arvalid;
  logic [7:0]  lsu_rstrb;
  logic [31:0] lsu_rdata;
  logic        lsu_rvalid;
  logic [31:0] lsu_awaddr;
  logic [31:0] lsu_wdata;
  logic [7:0]  lsu_wstrb;
  logic        lsu_awvalid;
  logic        lsu_wvalid;
  logic        lsu_wready;
  logic        lsu_err;
  logic [31:0] m_araddr;
  logic        m_arvalid;
  logic        m_arready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rvalid;
  logic        m_rready;
  logic [31:0] m_awaddr;
  logic        m_awvalid;
  logic        m_awready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wvalid;
  logic        m_wready;
  logic [1:0]  m_bresp;
  logic        m_bvalid;
  logic        m_bready;

  typedef struct packed {
    logic        is_load;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   n_b      = 0;
  int   n_aw     = 0;
  int   n_w      = 0;

  ysyx_lsu_axi #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .lsu_araddr (lsu_araddr),
    .lsu_arvalid(lsu_arvalid),
    .lsu_rstrb  (lsu_rstrb),
    .lsu_rdata  (lsu_rdata),
    .lsu_rvalid (lsu_rvalid),
    .lsu_awaddr (lsu_awaddr),
    .lsu_wdata  (lsu_wdata),
    .lsu_wstrb  (lsu_wstrb),
    .lsu_awvalid(lsu_awvalid),
    .lsu_wvalid (lsu_wvalid),
    .lsu_wready (lsu_wready),
    .lsu_err    (lsu_err),
    .m_araddr   (m_araddr),
    .m_arvalid  (m_arvalid),
    .m_arready  (m_arready),
    .m_rdata    (m_rdata),
    .m_rresp    (m_rresp),
    .m_rvalid   (m_rvalid),
    .m_rready   (m_rready),
    .m_awaddr   (m_awaddr),
    .m_awvalid  (m_awvalid),
    .m_awready  (m_awready),
    .m_wdata    (m_wdata),
    .m_wstrb    (m_wstrb),
    .m_wvalid   (m_wvalid),
    .m_wready   (m_wready),
    .m_bresp    (m_bresp),
    .m_bvalid   (m_bvalid),
    .m_bready   (m_bready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, counting handshakes due at this edge, then sample
  // 1 time unit after the edge and score any completion pulse.
  task automatic tick();
    exp_t e;
    if (m_bvalid && m_bready) n_b++;
    if (m_awvalid && m_awready) n_aw++;
    if (m_wvalid && m_wready) n_w++;
    @(posedge clk);
    #1;
    if (lsu_rvalid || lsu_wready) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", 32'(lsu_rvalid | lsu_wready), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_kind", 32'(lsu_rvalid), 32'(e.is_load));
        chk("sb_both_pulses", 32'(lsu_rvalid & lsu_wready), 32'd0);
        if (e.is_load) chk("sb_rdata", lsu_rdata, e.data);
        chk("sb_err", 32'(lsu_err), 32'(e.err));
      end
    end
  endtask

  // Load against a zero-wait slave, checking cycle-exact timing.
  task automatic do_load(input string tag, input logic [31:0] addr, input logic [7:0] strb,
                         input logic [31:0] slave_data, input logic [1:0] resp,
                         input logic [31:0] exp_data);
    lsu_araddr  = addr;
    lsu_rstrb   = strb;
    lsu_arvalid = 1'b1;
    m_arready   = 1'b1;
    sb.push_back('{1'b1, exp_data, (resp != 2'b00)});
    tick();
    chk({tag, "_c1_arvalid"}, 32'(m_arvalid), 32'd1);
    chk({tag, "_c1_araddr"}, m_araddr, addr);
    chk({tag, "_c1_awvalid"}, 32'(m_awvalid), 32'd0);
    tick();
    chk({tag, "_c2_arvalid"}, 32'(m_arvalid), 32'd0);
    chk({tag, "_c2_rready"}, 32'(m_rready), 32'd1);
    m_rvalid = 1'b1;
    m_rdata  = slave_data;
    m_rresp  = resp;
    tick();
    chk({tag, "_c3_rvalid"}, 32'(lsu_rvalid), 32'd1);
    chk({tag, "_c3_err"}, 32'(lsu_err), 32'(resp != 2'b00));
    chk({tag, "_c3_rready"}, 32'(m_rready), 32'd0);
    m_rvalid    = 1'b0;
    m_rresp     = 2'b00;
    lsu_arvalid = 1'b0;
    tick();
    chk({tag, "_c4_rvalid"}, 32'(lsu_rvalid), 32'd0);
    chk({tag, "_c4_hold_idle"}, 32'({m_arvalid, m_awvalid}), 32'd0);
    chk({tag, "_c4_rdata_held"}, lsu_rdata, exp_data);
  endtask

  // Store against a zero-wait slave, checking lane alignment and timing.
  task automatic do_store(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input logic [7:0] strb, input logic [31:0] exp_wdata,
                          input logic [3:0] exp_wstrb);
    lsu_awaddr  = addr;
    lsu_wdata   = data;
    lsu_wstrb   = strb;
    lsu_awvalid = 1'b1;
    lsu_wvalid  = 1'b1;
    m_awready   = 1'b1;
    m_wready    = 1'b1;
    sb.push_back('{1'b0, 32'h0000_0000, 1'b0});
    tick();
    chk({tag, "_c1_awvalid"}, 32'(m_awvalid), 32'd1);
    chk({tag, "_c1_wvalid"}, 32'(m_wvalid), 32'd1);
    chk({tag, "_c1_awaddr"}, m_awaddr, addr);
    chk({tag, "_c1_wdata"}, m_wdata, exp_wdata);
    chk({tag, "_c1_wstrb"}, 32'(m_wstrb), 32'(exp_wstrb));
    tick();
    chk({tag, "_c2_valids"}, 32'({m_awvalid, m_wvalid}), 32'd0);
    chk({tag, "_c2_bready"}, 32'(m_bready), 32'd1);
    m_bvalid = 1'b1;
    m_bresp  = 2'b00;
    tick();
    chk({tag, "_c3_wready"}, 32'(lsu_wready), 32'd1);
    chk({tag, "_c3_bready"}, 32'(m_bready), 32'd0);
    m_bvalid    = 1'b0;
    lsu_awvalid = 1'b0;
    lsu_wvalid  = 1'b0;
    tick();
    chk({tag, "_c4_wready"}, 32'(lsu_wready), 32'd0);
  endtask

  initial begin
    int b0, aw0, w0;
    rst = 1'b1;
    lsu_araddr = 32'h0; lsu_arvalid = 1'b0; lsu_rstrb = 8'h0;
    lsu_awaddr = 32'h0; lsu_wdata = 32'h0; lsu_wstrb = 8'h0;
    lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
    m_arready = 1'b0; m_rdata = 32'h0; m_rresp = 2'b00; m_rvalid = 1'b0;
    m_awready = 1'b0; m_wready = 1'b0; m_bresp = 2'b00; m_bvalid = 1'b0;
    tick();
    tick();
    chk("reset_ctrl", 32'({m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready,
                           lsu_rvalid, lsu_wready, lsu_err}), 32'd0);
    chk("reset_rdata", lsu_rdata, 32'd0);
    rst = 1'b0;
    tick();

    // LW, aligned
    do_load("lw", 32'h8000_0010, 8'h0f, 32'hDEAD_BEEF, 2'b00, 32'hDEAD_BEEF);
    // LBU at offset 3: top byte shifted down to bit 0
    do_load("lbu", 32'h8000_0103, 8'h01, 32'h1122_3344, 2'b00, 32'h0000_0011);
    // SH at offset 2
    do_store("sh", 32'h8000_0102, 32'h0000_ABCD, 8'h03, 32'hABCD_0000, 4'b1100);

    // SW with AW stalled for 3 cycles while W is accepted at once
    b0 = n_b; aw0 = n_aw; w0 = n_w;
    lsu_awaddr = 32'h8000_0200; lsu_wdata = 32'h1234_5678; lsu_wstrb = 8'h0f;
    lsu_awvalid = 1'b1; lsu_wvalid = 1'b1;
    m_awready = 1'b0; m_wready = 1'b1;
    sb.push_back('{1'b0, 32'h0000_0000, 1'b0});
    tick();
    chk("slow_c1_valids", 32'({m_awvalid, m_wvalid}), 32'd3);
    tick();
    chk("slow_c2_wvalid", 32'(m_wvalid), 32'd0);
    chk("slow_c2_awvalid", 32'(m_awvalid), 32'd1);
    tick();
    chk("slow_c3_awvalid", 32'(m_awvalid), 32'd1);
    chk("slow_c3_awaddr", m_awaddr, 32'h8000_0200);
    chk("slow_c3_bready", 32'(m_bready), 32'd0);
    m_awready = 1'b1;
    tick();
    chk("slow_c4_awvalid", 32'(m_awvalid), 32'd0);
    chk("slow_c4_bready", 32'(m_bready), 32'd1);
    m_bvalid = 1'b1;
    tick();
    chk("slow_c5_wready", 32'(lsu_wready), 32'd1);
    lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
    tick();
    m_bvalid = 1'b0;
    chk("slow_c6_wready", 32'(lsu_wready), 32'd0);
    chk("slow_b_count", 32'(n_b - b0), 32'd1);
    chk("slow_aw_count", 32'(n_aw - aw0), 32'd1);
    chk("slow_w_count", 32'(n_w - w0), 32'd1);
    tick();

    // Load with SLVERR response
    do_load("lerr", 32'h8000_0020, 8'h0f, 32'h55AA_55AA, 2'b10, 32'h55AA_55AA);

    // Load and store requested together: load first, store right after HOLD
    lsu_awaddr = 32'h8000_0300; lsu_wdata = 32'hCAFE_F00D; lsu_wstrb = 8'h0f;
    lsu_awvalid = 1'b1; lsu_wvalid = 1'b1;
    do_load("prio", 32'h8000_0040, 8'h0f, 32'h0102_0304, 2'b00, 32'h0102_0304);
    do_store("b2b", 32'h8000_0300, 32'hCAFE_F00D, 8'h0f, 32'hCAFE_F00D, 4'b1111);

    // Reset while waiting in RDATA
    lsu_araddr = 32'h8000_0080; lsu_rstrb = 8'h0f; lsu_arvalid = 1'b1; m_arready = 1'b1;
    tick();
    tick();
    chk("rst_pre_rready", 32'(m_rready), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_ctrl", 32'({m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready,
                             lsu_rvalid, lsu_wready, lsu_err}), 32'd0);
    chk("rst_mid_rdata", lsu_rdata, 32'd0);
    lsu_arvalid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_after_idle", 32'({m_arvalid, m_rready}), 32'd0);
    do_load("lw2", 32'h8000_0010, 8'h0f, 32'h600D_F00D, 2'b00, 32'h600D_F00D);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("total_b_count", 32'(n_b), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
